// File: rtl/wiener_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : wiener_pkg
// Brief  : Shared types and helpers for the Wiener filter frame sequencer.
// Rev    : 1.0
// ============================================================================
package wiener_pkg;

    typedef enum logic [2:0] {
        WFC_IDLE     = 3'd0,
        WFC_WAIT_SOF = 3'd1,
        WFC_ACTIVE   = 3'd2,
        WFC_FLUSH    = 3'd3,
        WFC_DONE     = 3'd4
    } wfc_state_t;

    localparam int WFC_FRAME_CNT_W = 16;

    // Counter width able to hold the value max_val itself.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wiener_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : wiener_frame_ctrl_if
// Brief  : Pixel stream handshake (valid/last/user=SOF/ready).
// Rev    : 1.0
// ============================================================================
interface wiener_frame_ctrl_if;
    logic s_valid;
    logic s_last;
    logic s_user;
    logic s_ready;

    modport master (output s_valid, output s_last, output s_user, input  s_ready);
    modport slave  (input  s_valid, input  s_last, input  s_user, output s_ready);
endinterface
`default_nettype wire

// File: rtl/wiener_frame_ctrl_pixel_xy_counter.sv
`default_nettype none
// ============================================================================
// Module : pixel_xy_counter
// Brief  : Pixel x/y tracker with line/frame end flags and SOF restart.
// Rev    : 1.0
// ============================================================================
module pixel_xy_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic             i_restart,
    input  logic             i_last,
    input  logic [CNT_W-1:0] i_w_m1,
    input  logic [CNT_W-1:0] i_h_m1,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_x_at_end,
    output logic             o_frame_end
);

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             w_x_at_end;
    logic             w_line_end;
    logic             w_frame_end;

    assign w_x_at_end = (r_x == i_w_m1);

    // A restart beat is pixel (0,0) no matter where the counters stand.
    always_comb begin
        w_line_end  = 1'b0;
        w_frame_end = 1'b0;
        if (i_restart) begin
            w_line_end  = (i_w_m1 == '0);
            w_frame_end = w_line_end && (i_h_m1 == '0);
        end else begin
            w_line_end  = w_x_at_end || i_last;
            w_frame_end = w_line_end && (r_y == i_h_m1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_frame_end) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_line_end) begin
                r_x <= '0;
                r_y <= i_restart ? CNT_W'(1) : r_y + CNT_W'(1);
            end else begin
                r_x <= i_restart ? CNT_W'(1) : r_x + CNT_W'(1);
                r_y <= i_restart ? '0 : r_y;
            end
        end
    end

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_x_at_end  = w_x_at_end;
    assign o_frame_end = w_frame_end;

endmodule
`default_nettype wire

// File: rtl/wiener_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : wiener_frame_ctrl
// Brief  : Frame sequencer gating stats/filter units and flushing the pipeline.
// Rev    : 1.0
// ============================================================================
module wiener_frame_ctrl
    import wiener_pkg::*;
#(
    parameter  int MAX_W    = 1024,
    parameter  int MAX_H    = 1024,
    parameter  int PIPE_LAT = 4,
    localparam int CNT_W    = cnt_width((MAX_W > MAX_H) ? MAX_W : MAX_H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_enable,
    input  logic [CNT_W-1:0]           cfg_width,
    input  logic [CNT_W-1:0]           cfg_height,
    wiener_frame_ctrl_if.slave         s_axis,
    output logic                       stats_clear,
    output logic                       stats_en,
    output logic [CNT_W-1:0]           pix_x,
    output logic [CNT_W-1:0]           pix_y,
    output logic                       frame_done,
    output logic [WFC_FRAME_CNT_W-1:0] frame_cnt,
    output logic                       err_len,
    output logic                       err_sof,
    output logic                       busy
);

    localparam int             FL_W         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [FL_W-1:0] c_FLUSH_LAST = FL_W'(PIPE_LAT - 1);

    wfc_state_t                 r_state;
    logic                       r_s_ready;
    logic                       r_frame_done;
    logic                       r_busy;
    logic                       r_err_len;
    logic                       r_err_sof;
    logic [CNT_W-1:0]           r_w_m1;
    logic [CNT_W-1:0]           r_h_m1;
    logic [FL_W-1:0]            r_flush_cnt;
    logic [WFC_FRAME_CNT_W-1:0] r_frame_cnt;

    logic w_acc;
    logic w_in_frame;
    logic w_adv;
    logic w_cfg_ok;
    logic w_x_at_end;
    logic w_frame_end;

    assign w_acc      = s_axis.s_valid & r_s_ready;
    assign w_in_frame = (r_state == WFC_ACTIVE);
    // Only WAIT_SOF and ACTIVE accept, so a non-ACTIVE accept with user set is the SOF.
    assign w_adv      = w_acc & (w_in_frame | s_axis.s_user);
    assign w_cfg_ok   = cfg_enable & (cfg_width != '0) & (cfg_height != '0);

    pixel_xy_counter #(
        .CNT_W (CNT_W)
    ) u_xy (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (w_adv),
        .i_restart   (s_axis.s_user),
        .i_last      (s_axis.s_last),
        .i_w_m1      (r_w_m1),
        .i_h_m1      (r_h_m1),
        .o_x         (pix_x),
        .o_y         (pix_y),
        .o_x_at_end  (w_x_at_end),
        .o_frame_end (w_frame_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= WFC_IDLE;
            r_s_ready    <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_err_len    <= 1'b0;
            r_err_sof    <= 1'b0;
            r_w_m1       <= '0;
            r_h_m1       <= '0;
            r_flush_cnt  <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_err_len    <= w_acc & w_in_frame & (s_axis.s_last ^ w_x_at_end);
            r_err_sof    <= w_acc & w_in_frame & s_axis.s_user;
            r_frame_done <= 1'b0;
            case (r_state)
                WFC_IDLE: begin
                    if (w_cfg_ok) begin
                        r_w_m1    <= cfg_width - CNT_W'(1);
                        r_h_m1    <= cfg_height - CNT_W'(1);
                        r_state   <= WFC_WAIT_SOF;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                WFC_WAIT_SOF, WFC_ACTIVE: begin
                    if (w_adv) begin
                        if (w_frame_end) begin
                            r_state     <= WFC_FLUSH;
                            r_s_ready   <= 1'b0;
                            r_flush_cnt <= '0;
                        end else begin
                            r_state     <= WFC_ACTIVE;
                        end
                    end
                end
                WFC_FLUSH: begin
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_state      <= WFC_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_flush_cnt  <= r_flush_cnt + FL_W'(1);
                    end
                end
                WFC_DONE: begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    if (w_cfg_ok) begin
                        r_w_m1    <= cfg_width - CNT_W'(1);
                        r_h_m1    <= cfg_height - CNT_W'(1);
                        r_state   <= WFC_WAIT_SOF;
                        r_s_ready <= 1'b1;
                    end else begin
                        r_state   <= WFC_IDLE;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= WFC_IDLE;
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis.s_ready = r_s_ready;
    assign stats_clear    = w_acc & s_axis.s_user;
    assign stats_en       = w_adv;
    assign frame_done     = r_frame_done;
    assign frame_cnt      = r_frame_cnt;
    assign err_len        = r_err_len;
    assign err_sof        = r_err_sof;
    assign busy           = r_busy;

endmodule
`default_nettype wire
